// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the integer register file
package regfile_pkg;

    localparam int NREGS_DEF  = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    // An address names real, writable state: not x0 and not past the array end.
    function automatic logic addr_live(input int addr, input int nregs);
        return (addr != int'(ZERO_REG)) && (addr < nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy flags with flush/set/clear priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              CK,
    input  logic              RESET,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && addr_live(int'(set_addr), NREGS)) begin
            set_vec[set_addr] = 1'b1;
        end
        if (wr_en && addr_live(int'(wr_addr), NREGS)) begin
            clr_vec[wr_addr] = 1'b1;
        end
    end

    // Set is OR'd in after the clear so a newly issued writer outranks the retiring one.
    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            busy_q <= '0;
        end else if (flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
        end
    end

    always_comb begin
        rd1_busy = 1'b0;
        rd2_busy = 1'b0;
        if (addr_live(int'(rd1_addr), NREGS)) begin
            rd1_busy = busy_q[rd1_addr] && !(wr_en && wr_addr == rd1_addr);
        end
        if (addr_live(int'(rd2_addr), NREGS)) begin
            rd2_busy = busy_q[rd2_addr] && !(wr_en && wr_addr == rd2_addr);
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - 2-read 1-write register file with write bypass and busy scoreboard
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter  int NBITS  = 32,
    parameter  int NREGS  = NREGS_DEF,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              CK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [NBITS-1:0]  rs1_data,
    output logic              rs1_busy,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [NBITS-1:0]  rs2_data,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NBITS-1:0]  wr_data,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    input  logic              flush
);

    logic [NBITS-1:0] regs [NREGS];
    logic             wr_live;
    logic             rs1_live;
    logic             rs2_live;

    assign wr_live  = wr_en && addr_live(int'(wr_addr), NREGS);
    assign rs1_live = addr_live(int'(rs1_addr), NREGS);
    assign rs2_live = addr_live(int'(rs2_addr), NREGS);

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // RESET also masks the bypass path so decode sees zeros while reset is held.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!RESET && rs1_live) begin
            rs1_data = (wr_live && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
        end
        if (!RESET && rs2_live) begin
            rs2_data = (wr_live && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .CK       (CK),
        .RESET    (RESET),
        .set_en   (sb_set_en),
        .set_addr (sb_set_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .rd1_addr (rs1_addr),
        .rd2_addr (rs2_addr),
        .rd1_busy (rs1_busy),
        .rd2_busy (rs2_busy)
    );

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Integer register file for the RISC-V-lite core: two asynchronous read ports for decode, one synchronous write port for writeback.
- Write-to-read bypass: a same-cycle writeback value is visible to decode.
- Per-register busy scoreboard: decode uses it to stall on RAW hazards against in-flight instructions.
- x0 is hardwired to zero and is never busy.

Parameters:
- NBITS, 32, data width of each register.
- NREGS, 32, number of architectural registers; ADDR_W = $clog2(NREGS) is derived, not overridable.

Ports:
- CK  in  1  clock, all state updates on rising edge.
- RESET  in  1  asynchronous reset, active-high.
- rs1_addr  in  ADDR_W  read port 1 address.
- rs1_data  out  NBITS  read port 1 data.
- rs1_busy  out  1  rs1 has a pending writer.
- rs2_addr  in  ADDR_W  read port 2 address.
- rs2_data  out  NBITS  read port 2 data.
- rs2_busy  out  1  rs2 has a pending writer.
- wr_en  in  1  writeback valid.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  NBITS  writeback value.
- sb_set_en  in  1  instruction issued with a destination register.
- sb_set_addr  in  ADDR_W  destination of the issued instruction.
- flush  in  1  squash all in-flight writers (clear every busy bit).

Behaviour:
- Reset (CK and RESET as named here; RESET is asynchronous, active-high):
  - All registers become 0 and all busy bits become 0 immediately, independent of CK.
  - While RESET is high, rsX_data = 0 and rsX_busy = 0 for every address.
  - Reset asserted mid-operation discards any pending write or set.
- Reads:
  - Combinational, zero latency.
  - rsX_data = wr_data if wr_en && wr_addr == rsX_addr && rsX_addr != 0.
  - Otherwise rsX_data = 0 if rsX_addr == 0.
  - Otherwise rsX_data = regs[rsX_addr].
- Write: on rising CK, if wr_en && wr_addr != 0, then regs[wr_addr] <= wr_data. Writes to x0 are silently dropped.
- Busy outputs:
  - rsX_busy = busy_q[rsX_addr] && !(wr_en && wr_addr == rsX_addr); the bypassed value is considered available.
  - rsX_busy = 0 when rsX_addr == 0.
- Scoreboard update at rising CK, per register i != 0, in priority order:
  1. flush: busy_q[i] <= 0 for all i. sb_set_en is ignored in that cycle; the write still commits.
  2. sb_set_en && sb_set_addr == i: busy_q[i] <= 1. Set wins over a same-cycle clear, because the new writer supersedes the retiring one.
  3. wr_en && wr_addr == i: busy_q[i] <= 0.
  4. Otherwise hold.
- sb_set_en with sb_set_addr == 0 has no effect.
- Both read ports may address the same register; both return identical data and busy.
- No state machine beyond per-entry busy flags. The data array and the scoreboard are independent.
- Out-of-range addresses (NREGS not a power of two): reads return 0 and busy 0; writes and sets are ignored.

Decomposition:
- Package regfile_pkg:
  - localparams NREGS_DEF = 32 and ADDR_W_DEF = 5.
  - typedef reg_addr_t (logic [ADDR_W_DEF-1:0]).
  - constant ZERO_REG = '0.
- Sub-module regfile_scoreboard holds the NREGS busy flags, with the set/clear/flush priority above and the two busy lookups.
- The top level holds the data array, bypass muxes and the x0 masking.

Test Plan:
- Assert RESET for 3 cycles, then sweep rs1_addr 0..31 -> rs1_data = 0 and rs1_busy = 0 for all. Re-assert RESET between edges -> state clears immediately, with no edge needed.
- wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rs1_addr=5 in the same cycle -> rs1_data = 0xDEADBEEF before the edge (bypass). Next cycle with wr_en=0 -> rs1_data is still 0xDEADBEEF.
- Write 0x12345678 to x0, then read rs1_addr=0 and rs2_addr=0 -> both data 0. sb_set_en with sb_set_addr=0 -> busy stays 0.
- sb_set_en=1, sb_set_addr=7 -> next cycle rs2_addr=7 gives rs2_busy=1. Then wr_en=1, wr_addr=7, data 0x55 -> rs2_busy=0 combinationally that cycle and stays 0 after the edge.
- Busy x9, then in one cycle sb_set_addr=9 and wr_addr=9, wr_data 0xAA -> after the edge, regs[9]=0xAA and busy_q[9]=1 (set wins).
- Busy x3 and x4, then flush=1 with sb_set_addr=6 -> next cycle x3, x4 and x6 all report busy=0. A write to x3 issued in the flush cycle is committed.
